cpu_control_unit: RTL and testbench

- Multi-cycle fetch/decode/execute sequencer for the 16-bit accumulator CPU.
- Drives the write strobes and mux selects of PC, MAR, MBR, IR and ACC, the ALU opcode and the main-memory write enable.
- Instruction format: opcode `instr[15:12]`, operand address `instr[11:0]`.
- Main memory is word-addressed with a registered (1-cycle) read.

---
 rtl/cpu_control_unit.sv | 178 +++++++++++++++++
 tb/tb_cpu_control_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator CPU.
// Outputs are decoded from the current state and IR; only state, retired and illegal are registered.
module cpu_control_unit #(
    parameter int RETIRED_W = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [15:0]          instr,
    input  logic                 acc_neg,
    input  logic                 acc_zero,
    output logic                 pc_write,
    output logic                 pc_sel,
    output logic                 mar_write,
    output logic                 mar_sel,
    output logic                 ir_write,
    output logic                 mbr_write,
    output logic                 mbr_sel,
    output logic                 acc_write,
    output logic                 acc_sel,
    output logic [3:0]           alu_opcode,
    output logic                 mem_write,
    output logic                 halted,
    output logic                 illegal,
    output logic [3:0]           state,
    output logic [RETIRED_W-1:0] retired
);

    // state       | meaning
    // IDLE        | waiting for start
    // FETCH_ADDR  | MAR <= PC
    // FETCH_READ  | instruction read in flight
    // FETCH_LOAD  | IR <= mem, PC <= PC+1
    // DECODE      | dispatch on opcode; JUMP/SKIPCOND load PC here
    // EXEC_READ   | operand read in flight
    // EXEC_MBR    | MBR <= mem
    // EXEC_ACC    | ACC <= MBR or ALU result
    // STORE_MBR   | MBR <= ACC
    // STORE_WRITE | mem[MAR] <= MBR
    // HALTED      | parked until reset
    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        FETCH_ADDR  = 4'd1,
        FETCH_READ  = 4'd2,
        FETCH_LOAD  = 4'd3,
        DECODE      = 4'd4,
        EXEC_READ   = 4'd5,
        EXEC_MBR    = 4'd6,
        EXEC_ACC    = 4'd7,
        STORE_MBR   = 4'd8,
        STORE_WRITE = 4'd9,
        HALTED      = 4'd10
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_JUMP  = 4'h5;
    localparam logic [3:0] OP_SKIP  = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'h7;

    localparam logic [RETIRED_W-1:0] RETIRED_ONE = {{(RETIRED_W-1){1'b0}}, 1'b1};

    state_t     state_q;
    logic [3:0] opcode;
    logic       skip_taken;
    logic       unused_operand_bits;

    assign opcode              = instr[15:12];
    assign state               = state_q;
    assign unused_operand_bits = ^instr[9:0];

    always_comb begin
        case (instr[11:10])
            2'b00:   skip_taken = acc_neg;
            2'b01:   skip_taken = acc_zero;
            2'b10:   skip_taken = !acc_neg && !acc_zero;
            default: skip_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            retired <= '0;
            illegal <= 1'b0;
        end else begin
            case (state_q)
                IDLE:        if (start) state_q <= FETCH_ADDR;
                FETCH_ADDR:  state_q <= FETCH_READ;
                FETCH_READ:  state_q <= FETCH_LOAD;
                FETCH_LOAD:  state_q <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_NOP, OP_JUMP, OP_SKIP: begin
                            state_q <= FETCH_ADDR;
                            retired <= retired + RETIRED_ONE;
                        end
                        OP_LOAD, OP_ADD, OP_SUB: state_q <= EXEC_READ;
                        OP_STORE:                state_q <= STORE_MBR;
                        OP_HALT: begin
                            state_q <= HALTED;
                            retired <= retired + RETIRED_ONE;
                        end
                        default: begin
                            state_q <= HALTED;
                            illegal <= 1'b1;
                        end
                    endcase
                end
                EXEC_READ:   state_q <= EXEC_MBR;
                EXEC_MBR:    state_q <= EXEC_ACC;
                EXEC_ACC, STORE_WRITE: begin
                    state_q <= FETCH_ADDR;
                    retired <= retired + RETIRED_ONE;
                end
                STORE_MBR:   state_q <= STORE_WRITE;
                HALTED:      state_q <= HALTED;
                default:     state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        pc_sel     = 1'b0;
        mar_write  = 1'b0;
        mar_sel    = 1'b0;
        ir_write   = 1'b0;
        mbr_write  = 1'b0;
        mbr_sel    = 1'b0;
        acc_write  = 1'b0;
        acc_sel    = 1'b0;
        alu_opcode = 4'b0000;
        mem_write  = 1'b0;
        halted     = 1'b0;
        case (state_q)
            FETCH_ADDR: mar_write = 1'b1;
            FETCH_LOAD: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
            end
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_ADD, OP_SUB, OP_STORE: begin
                        mar_write = 1'b1;
                        mar_sel   = 1'b1;
                    end
                    OP_JUMP: begin
                        pc_write = 1'b1;
                        pc_sel   = 1'b1;
                    end
                    OP_SKIP: pc_write = skip_taken;
                    default: ;
                endcase
            end
            EXEC_MBR: mbr_write = 1'b1;
            EXEC_ACC: begin
                acc_write = 1'b1;
                case (opcode)
                    OP_LOAD: acc_sel    = 1'b1;
                    OP_SUB:  alu_opcode = 4'b0001;
                    default: ;
                endcase
            end
            STORE_MBR: begin
                mbr_write = 1'b1;
                mbr_sel   = 1'b1;
            end
            STORE_WRITE: mem_write = 1'b1;
            HALTED:      halted    = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: a small datapath/memory model closes the loop
// around the sequencer so whole programs can be executed and checked.
module tb_cpu_control_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] instr;
    logic        acc_neg, acc_zero;
    logic        pc_write, pc_sel, mar_write, mar_sel, ir_write;
    logic        mbr_write, mbr_sel, acc_write, acc_sel, mem_write;
    logic        halted, illegal;
    logic [3:0]  alu_opcode, state;
    logic [3:0]  retired;

    logic [15:0] pc, mar, mbr, ir, acc, mem_data;
    logic [15:0] mem [0:4095];

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [3:0] S_IDLE = 4'd0, S_FA = 4'd1, S_DEC = 4'd4, S_EMBR = 4'd6, S_HALT = 4'd10;

    cpu_control_unit #(.RETIRED_W(4)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .instr(instr),
        .acc_neg(acc_neg), .acc_zero(acc_zero),
        .pc_write(pc_write), .pc_sel(pc_sel), .mar_write(mar_write), .mar_sel(mar_sel),
        .ir_write(ir_write), .mbr_write(mbr_write), .mbr_sel(mbr_sel),
        .acc_write(acc_write), .acc_sel(acc_sel), .alu_opcode(alu_opcode),
        .mem_write(mem_write), .halted(halted), .illegal(illegal),
        .state(state), .retired(retired)
    );

    always #5 clock = ~clock;

    assign instr    = ir;
    assign acc_neg  = acc[15];
    assign acc_zero = (acc == 16'h0000);

    // Datapath model: registered memory read, registers loaded by the strobes.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc <= '0; mar <= '0; mbr <= '0; ir <= '0; acc <= '0; mem_data <= '0;
        end else begin
            mem_data <= mem[mar[11:0]];
            if (mem_write) mem[mar[11:0]] <= mbr;
            if (pc_write)  pc  <= pc_sel  ? {4'b0, ir[11:0]} : pc + 16'd1;
            if (mar_write) mar <= mar_sel ? {4'b0, ir[11:0]} : pc;
            if (ir_write)  ir  <= mem_data;
            if (mbr_write) mbr <= mbr_sel ? acc : mem_data;
            if (acc_write) acc <= acc_sel ? mbr :
                                  (alu_opcode == 4'b0001 ? acc - mbr : acc + mbr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_and_clear();
        reset_n = 1'b0;
        start   = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) mem[i] <= 16'h0000;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_state(input logic [3:0] s, input int max);
        int n = 0;
        while (state !== s && n < max) begin
            tick();
            n++;
        end
        check("wait_state", {28'd0, state}, {28'd0, s});
    endtask

    task automatic next_decode();
        tick();
        run_to_state(S_DEC, 20);
    endtask

    function automatic logic [11:0] strobes();
        return {pc_write, pc_sel, mar_write, mar_sel, ir_write, mbr_write,
                mbr_sel, acc_write, acc_sel, mem_write, halted, illegal};
    endfunction

    initial begin
        int n;

        // 1: reset asserted mid-EXEC_MBR of a LOAD
        reset_and_clear();
        mem[0] <= 16'h1010; mem[16'h10] <= 16'h1234;
        #1;
        check("reset_state", {28'd0, state}, 32'd0);
        check("reset_strobes", {20'd0, strobes(), alu_opcode}, 32'd0);
        release_reset();
        start_run();
        check("start_to_fa", {28'd0, state}, {28'd0, S_FA});
        run_to_state(S_EMBR, 20);
        check("embr_strobe", {31'd0, mbr_write}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_state", {28'd0, state}, 32'd0);
        check("midreset_strobes", {20'd0, strobes(), alu_opcode}, 32'd0);
        check("midreset_retired", {28'd0, retired}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("restart_fa", {28'd0, state}, {28'd0, S_FA});
        check("no_partial_acc", {16'd0, acc}, 32'd0);

        // 2: LOAD/ADD/STORE/HALT program
        reset_and_clear();
        mem[0] <= 16'h1010; mem[1] <= 16'h3011; mem[2] <= 16'h2012; mem[3] <= 16'h7000;
        mem[16'h10] <= 16'd5; mem[16'h11] <= 16'd7;
        release_reset();
        start_run();
        n = 0;
        while (!halted && n < 100) begin
            tick();
            n++;
        end
        check("prog_cycles", n, 32'd24);
        check("prog_mem12", {16'd0, mem[16'h12]}, 32'd12);
        check("prog_acc", {16'd0, acc}, 32'd12);
        check("prog_retired", {28'd0, retired}, 32'd4);
        check("prog_state", {28'd0, state}, {28'd0, S_HALT});

        // 3: JUMP 0x5020
        reset_and_clear();
        mem[0] <= 16'h5020; mem[16'h20] <= 16'h7000;
        release_reset();
        start_run();
        run_to_state(S_DEC, 20);
        check("jump_pc_strobe", {30'd0, pc_write, pc_sel}, 32'd3);
        check("jump_retired_pre", {28'd0, retired}, 32'd0);
        tick();
        check("jump_fa", {28'd0, state}, {28'd0, S_FA});
        check("jump_retired", {28'd0, retired}, 32'd1);
        check("jump_pc", {16'd0, pc}, 32'h20);
        check("jump_mar_ctl", {30'd0, mar_write, mar_sel}, 32'd2);
        tick();
        check("jump_mar", {16'd0, mar}, 32'h20);
        run_to_state(S_HALT, 20);
        check("jump_halt_retired", {28'd0, retired}, 32'd2);

        // 4a: SKIPCOND zero-test with ACC=0 -> taken
        reset_and_clear();
        mem[0] <= 16'h6400; mem[2] <= 16'h7000;
        release_reset();
        start_run();
        run_to_state(S_DEC, 20);
        check("skip0_strobe", {30'd0, pc_write, pc_sel}, 32'd2);
        check("skip0_pc_pre", {16'd0, pc}, 32'd1);
        tick();
        check("skip0_pc", {16'd0, pc}, 32'd2);
        run_to_state(S_HALT, 20);
        check("skip0_retired", {28'd0, retired}, 32'd2);

        // 4b: ACC=3: zero-test not taken, never-cond not taken, positive-test taken
        reset_and_clear();
        mem[0] <= 16'h1010; mem[1] <= 16'h6400; mem[2] <= 16'h6C00;
        mem[3] <= 16'h6800; mem[5] <= 16'h7000; mem[16'h10] <= 16'd3;
        release_reset();
        start_run();
        run_to_state(S_DEC, 20);
        check("skip_load_ir", {16'd0, ir}, 32'h1010);
        next_decode();
        check("skip3_ir", {16'd0, ir}, 32'h6400);
        check("skip3_strobe", {31'd0, pc_write}, 32'd0);
        tick();
        check("skip3_pc", {16'd0, pc}, 32'd2);
        next_decode();
        check("never_strobe", {31'd0, pc_write}, 32'd0);
        tick();
        check("never_pc", {16'd0, pc}, 32'd3);
        next_decode();
        check("pos_strobe", {30'd0, pc_write, pc_sel}, 32'd2);
        tick();
        check("pos_pc", {16'd0, pc}, 32'd5);
        run_to_state(S_HALT, 20);
        check("skip_retired", {28'd0, retired}, 32'd5);

        // 5: illegal opcode
        reset_and_clear();
        mem[0] <= 16'hA000;
        release_reset();
        start_run();
        run_to_state(S_HALT, 20);
        check("ill_flags", {30'd0, illegal, halted}, 32'd3);
        check("ill_retired", {28'd0, retired}, 32'd0);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        check("ill_start_ignored", {28'd0, state}, {28'd0, S_HALT});
        reset_n = 1'b0;
        #1;
        check("ill_cleared", {31'd0, illegal}, 32'd0);

        // 6: retired wrap with a 4-bit counter over a NOP stream
        reset_and_clear();
        release_reset();
        start_run();
        repeat (60) tick();
        check("wrap_pre", {28'd0, retired}, 32'd15);
        repeat (4) tick();
        check("wrap_zero", {28'd0, retired}, 32'd0);
        check("wrap_nop_timing", {28'd0, state}, {28'd0, S_FA});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
